decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/inst_package.sv | 55 +++++
 rtl/decode_issue_slot_decoder.sv | 21 ++
 rtl/decode_issue.sv | 154 +++++++++++++++
 tb/tb_decode_issue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_package.sv
// Shared definitions for the dual-issue decode stage: opcode encoding,
// instruction field positions, the decoded slot record, FSM states and a
// small register-match helper used by the hazard and split checks.
// Optional feature macro used by decode_issue: SLOT_DEP_CHECK_EN.
package inst_package;

    localparam int INST_W   = 32;
    localparam int BUNDLE_W = 2 * INST_W;
    localparam int OP_W     = 6;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP    = 6'h00,
        OP_LOAD   = 6'h01,
        OP_ADD    = 6'h02,
        OP_SUB    = 6'h03,
        OP_AND    = 6'h04,
        OP_OR     = 6'h05,
        OP_XOR    = 6'h06,
        OP_STORE  = 6'h07,
        OP_BRANCH = 6'h08
    } op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    typedef struct packed {
        logic             valid;
        op_e              op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
    } decoded_slot_t;

    // True when a valid slot sources register r; r0 never matches.
    function automatic logic reads_reg(input decoded_slot_t s, input logic [REG_W-1:0] r);
        return s.valid && (r != '0) && ((s.rs1 == r) || (s.rs2 == r));
    endfunction

endpackage

// File: rtl/decode_issue_slot_decoder.sv
// slot_decoder: purely combinational field extraction for one 32-bit slot.
// A slot is valid whenever its opcode is anything other than NOP.
module slot_decoder
    import inst_package::*;
(
    input  logic [INST_W-1:0] inst,
    output decoded_slot_t     slot
);

    // Slice the fixed field positions; rs2 and imm overlap by design.
    always_comb begin
        slot       = '0;
        slot.op    = op_e'(inst[OP_MSB:OP_LSB]);
        slot.rd    = inst[RD_MSB:RD_LSB];
        slot.rs1   = inst[RS1_MSB:RS1_LSB];
        slot.rs2   = inst[RS2_MSB:RS2_LSB];
        slot.imm   = inst[IMM_MSB:IMM_LSB];
        slot.valid = (inst[OP_MSB:OP_LSB] != OP_NOP);
    end

endmodule

// File: rtl/decode_issue.sv
// decode_issue: two-slot decode and issue stage.
// Decodes the fetched bundle, stalls on execute back-pressure and load-use
// hazards, flushes on a resolved branch, and registers the issue outputs.
// Optional feature: SLOT_DEP_CHECK_EN enables the intra-bundle split, where a
// slot1 that reads slot0's destination is issued one cycle after slot0.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal: the whole held bundle is still to be issued
//   ST_SPLIT | slot0 already issued; only slot1 of the held bundle remains
module decode_issue
    import inst_package::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_in,
    input  logic [BUNDLE_W-1:0] inst_in,
    input  logic                branch_flag,
    input  logic                ex_busy,
    input  logic                ex_load_valid,
    input  logic [REG_W-1:0]    ex_load_rd,
    output logic                interlock,
    output logic [31:0]         pc_out,
    output logic                slot0_valid,
    output logic [OP_W-1:0]     slot0_op,
    output logic [REG_W-1:0]    slot0_rd,
    output logic [REG_W-1:0]    slot0_rs1,
    output logic [REG_W-1:0]    slot0_rs2,
    output logic [IMM_W-1:0]    slot0_imm,
    output logic                slot1_valid,
    output logic [OP_W-1:0]     slot1_op,
    output logic [REG_W-1:0]    slot1_rd,
    output logic [REG_W-1:0]    slot1_rs1,
    output logic [REG_W-1:0]    slot1_rs2,
    output logic [IMM_W-1:0]    slot1_imm
);

    decoded_slot_t dec0;
    decoded_slot_t dec1;
    state_e        state;
    logic          load_use;
    logic          split_hit;

    slot_decoder u_dec0 (
        .inst (inst_in[BUNDLE_W-1:INST_W]),
        .slot (dec0)
    );

    slot_decoder u_dec1 (
        .inst (inst_in[INST_W-1:0]),
        .slot (dec1)
    );

    // Load-use: only slots not yet issued count; in SPLIT slot0 is already gone.
    always_comb begin
        load_use = 1'b0;
        if (ex_load_valid) begin
            load_use = reads_reg(dec1, ex_load_rd) ||
                       ((state == ST_RUN) && reads_reg(dec0, ex_load_rd));
        end
    end

`ifdef SLOT_DEP_CHECK_EN
    // Split when slot1 reads slot0's (non-zero) destination within one bundle.
    always_comb begin
        split_hit = (state == ST_RUN) && dec0.valid && reads_reg(dec1, dec0.rd);
    end
`else
    // Without the dependency check both slots always issue together.
    always_comb begin
        split_hit = 1'b0;
    end
`endif

    // Fetch freeze, resolved in priority order; a branch lets fetch redirect.
    always_comb begin
        interlock = 1'b0;
        if (rst) begin
            interlock = 1'b0;
        end else if (branch_flag) begin
            interlock = 1'b0;
        end else if (ex_busy) begin
            interlock = 1'b1;
        end else if (load_use) begin
            interlock = 1'b1;
        end else if (split_hit) begin
            interlock = 1'b1;
        end
    end

    // Issue FSM and output registers; stalled cycles keep pc and fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            pc_out      <= '0;
            slot0_valid <= 1'b0;
            slot0_op    <= '0;
            slot0_rd    <= '0;
            slot0_rs1   <= '0;
            slot0_rs2   <= '0;
            slot0_imm   <= '0;
            slot1_valid <= 1'b0;
            slot1_op    <= '0;
            slot1_rd    <= '0;
            slot1_rs1   <= '0;
            slot1_rs2   <= '0;
            slot1_imm   <= '0;
        end else if (branch_flag) begin
            state       <= ST_RUN;
            slot0_valid <= 1'b0;
            slot1_valid <= 1'b0;
        end else if (ex_busy) begin
            state       <= state;
        end else if (load_use) begin
            slot0_valid <= 1'b0;
            slot1_valid <= 1'b0;
        end else if (state == ST_SPLIT) begin
            state       <= ST_RUN;
            pc_out      <= pc_in;
            slot0_valid <= 1'b0;
            slot1_valid <= dec1.valid;
            slot1_op    <= dec1.op;
            slot1_rd    <= dec1.rd;
            slot1_rs1   <= dec1.rs1;
            slot1_rs2   <= dec1.rs2;
            slot1_imm   <= dec1.imm;
        end else if (split_hit) begin
            state       <= ST_SPLIT;
            pc_out      <= pc_in;
            slot0_valid <= dec0.valid;
            slot0_op    <= dec0.op;
            slot0_rd    <= dec0.rd;
            slot0_rs1   <= dec0.rs1;
            slot0_rs2   <= dec0.rs2;
            slot0_imm   <= dec0.imm;
            slot1_valid <= 1'b0;
        end else begin
            pc_out      <= pc_in;
            slot0_valid <= dec0.valid;
            slot0_op    <= dec0.op;
            slot0_rd    <= dec0.rd;
            slot0_rs1   <= dec0.rs1;
            slot0_rs2   <= dec0.rs2;
            slot0_imm   <= dec0.imm;
            slot1_valid <= dec1.valid;
            slot1_op    <= dec1.op;
            slot1_rd    <= dec1.rd;
            slot1_rs1   <= dec1.rs1;
            slot1_rs2   <= dec1.rs2;
            slot1_imm   <= dec1.imm;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed scoreboard bench for decode_issue. Expected issue results are
// pushed when a bundle is driven and popped after the following clock edge.
module tb_decode_issue;

    localparam logic [5:0] NOP = 6'h00;
    localparam logic [5:0] ADD = 6'h02;

    localparam int M_BOTH = 0;
    localparam int M_S0   = 1;
    localparam int M_S1   = 2;
    localparam int M_BUB  = 3;
    localparam int M_HOLD = 4;
    localparam int M_RST  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic [63:0] inst_in = '0;
    logic        branch_flag = 1'b0;
    logic        ex_busy = 1'b0;
    logic        ex_load_valid = 1'b0;
    logic [4:0]  ex_load_rd = '0;
    logic        interlock;
    logic [31:0] pc_out;
    logic        slot0_valid, slot1_valid;
    logic [5:0]  slot0_op, slot1_op;
    logic [4:0]  slot0_rd, slot0_rs1, slot0_rs2, slot1_rd, slot1_rs1, slot1_rs2;
    logic [15:0] slot0_imm, slot1_imm;

    typedef struct {
        logic        v0;
        logic        v1;
        logic        hold;
        logic [31:0] pc;
        logic [31:0] w0;
        logic [31:0] w1;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_assert = 0;
    int   n_fail = 0;

    decode_issue dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in),
        .branch_flag(branch_flag), .ex_busy(ex_busy),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .interlock(interlock), .pc_out(pc_out),
        .slot0_valid(slot0_valid), .slot0_op(slot0_op), .slot0_rd(slot0_rd),
        .slot0_rs1(slot0_rs1), .slot0_rs2(slot0_rs2), .slot0_imm(slot0_imm),
        .slot1_valid(slot1_valid), .slot1_op(slot1_op), .slot1_rd(slot1_rd),
        .slot1_rs1(slot1_rs1), .slot1_rs2(slot1_rs2), .slot1_imm(slot1_imm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'h0A5};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("slot0_valid", {31'b0, slot0_valid}, {31'b0, e.v0});
        chk("slot1_valid", {31'b0, slot1_valid}, {31'b0, e.v1});
        if (e.hold || e.v0 || e.v1) chk("pc_out", pc_out, e.pc);
        if (e.hold || e.v0) begin
            chk("slot0_op",  {26'b0, slot0_op},  {26'b0, e.w0[31:26]});
            chk("slot0_rd",  {27'b0, slot0_rd},  {27'b0, e.w0[25:21]});
            chk("slot0_rs1", {27'b0, slot0_rs1}, {27'b0, e.w0[20:16]});
            chk("slot0_rs2", {27'b0, slot0_rs2}, {27'b0, e.w0[15:11]});
            chk("slot0_imm", {16'b0, slot0_imm}, {16'b0, e.w0[15:0]});
        end
        if (e.hold || e.v1) begin
            chk("slot1_op",  {26'b0, slot1_op},  {26'b0, e.w1[31:26]});
            chk("slot1_rd",  {27'b0, slot1_rd},  {27'b0, e.w1[25:21]});
            chk("slot1_rs1", {27'b0, slot1_rs1}, {27'b0, e.w1[20:16]});
            chk("slot1_rs2", {27'b0, slot1_rs2}, {27'b0, e.w1[15:11]});
            chk("slot1_imm", {16'b0, slot1_imm}, {16'b0, e.w1[15:0]});
        end
    endtask

    // Drive one cycle of inputs, check interlock, then check the registered result.
    task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1, input logic br, input logic busy,
                        input logic lv, input logic [4:0] lrd,
                        input logic exp_il, input int mode);
        exp_t e;
        @(negedge clk);
        rst = r; pc_in = pc; inst_in = {i0, i1};
        branch_flag = br; ex_busy = busy; ex_load_valid = lv; ex_load_rd = lrd;
        #1;
        chk("interlock", {31'b0, interlock}, {31'b0, exp_il});
        e = last;
        e.hold = 1'b0;
        case (mode)
            M_BOTH: begin
                e.v0 = (i0[31:26] != NOP); e.v1 = (i1[31:26] != NOP);
                e.pc = pc; e.w0 = i0; e.w1 = i1;
            end
            M_S0: begin
                e.v0 = 1'b1; e.v1 = 1'b0; e.pc = pc; e.w0 = i0;
            end
            M_S1: begin
                e.v0 = 1'b0; e.v1 = (i1[31:26] != NOP); e.pc = pc; e.w1 = i1;
            end
            M_BUB: begin
                e.v0 = 1'b0; e.v1 = 1'b0;
            end
            M_HOLD: e.hold = 1'b1;
            default: begin
                e.v0 = 1'b0; e.v1 = 1'b0; e.hold = 1'b1;
                e.pc = '0; e.w0 = '0; e.w1 = '0;
            end
        endcase
        sb.push_back(e);
        last = e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            check_out(sb.pop_front());
        end
        if (mode == M_RST) chk("interlock_in_reset", {31'b0, interlock}, 32'd0);
    endtask

    initial begin
        logic [31:0] a0, a1, sp0, sp1;
        last = '{v0: 1'b0, v1: 1'b0, hold: 1'b0, pc: '0, w0: '0, w1: '0};
        a0  = ins(ADD, 5'd1, 5'd2, 5'd3);
        a1  = ins(ADD, 5'd4, 5'd5, 5'd6);
        sp0 = ins(ADD, 5'd7, 5'd1, 5'd2);
        sp1 = ins(ADD, 5'd8, 5'd7, 5'd3);

        // Reset holds everything clear; first edge after release issues both.
        step(1'b1, 32'h100, a0, a1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_RST);
        step(1'b0, 32'h100, a0, a1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_BOTH);

        // Load-use on slot0 rs1, then clear.
        step(1'b0, 32'h108, a0, a1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, M_BUB);
        step(1'b0, 32'h108, a0, a1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, M_BOTH);

        // r0 sources with a load to r0: no hazard.
        step(1'b0, 32'h110, ins(ADD, 5'd1, 5'd0, 5'd0), ins(ADD, 5'd2, 5'd0, 5'd3),
             1'b0, 1'b0, 1'b1, 5'd0, 1'b0, M_BOTH);

        // Execute busy for three cycles holds outputs.
        step(1'b0, 32'h118, a0, a1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, M_HOLD);
        step(1'b0, 32'h118, a0, a1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, M_HOLD);
        step(1'b0, 32'h118, a0, a1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, M_HOLD);
        step(1'b0, 32'h118, a0, a1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_BOTH);

        // Load-use via slot1 rs2, then a non-matching load.
        step(1'b0, 32'h120, a0, a1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, M_BUB);
        step(1'b0, 32'h120, a0, a1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, M_BOTH);

        // NOP slot never hazards and never issues.
        step(1'b0, 32'h128, ins(NOP, 5'd0, 5'd2, 5'd0), a1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, M_BOTH);

        // Slot0 writes r0: never a split.
        step(1'b0, 32'h130, ins(ADD, 5'd0, 5'd1, 5'd2), ins(ADD, 5'd8, 5'd0, 5'd3),
             1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_BOTH);

`ifdef SLOT_DEP_CHECK_EN
        // Dependent bundle splits across two cycles.
        step(1'b0, 32'h138, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, M_S0);
        step(1'b0, 32'h138, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_S1);
        // Branch during SPLIT flushes and returns to RUN.
        step(1'b0, 32'h140, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, M_S0);
        step(1'b0, 32'h140, sp0, sp1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, M_BUB);
        step(1'b0, 32'h148, a0, a1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_BOTH);
        // In SPLIT, a load matching only the issued slot0 is harmless.
        step(1'b0, 32'h150, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, M_S0);
        step(1'b0, 32'h150, sp0, sp1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, M_S1);
        // In SPLIT, a load matching slot1 bubbles and stays in SPLIT.
        step(1'b0, 32'h158, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, M_S0);
        step(1'b0, 32'h158, sp0, sp1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, M_BUB);
        step(1'b0, 32'h158, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_S1);
        // Reset mid-SPLIT discards the pending slot1.
        step(1'b0, 32'h160, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, M_S0);
`else
        // Without the dependency check the bundle issues at once.
        step(1'b0, 32'h138, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_BOTH);
        step(1'b0, 32'h140, sp0, sp1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, M_BUB);
        step(1'b0, 32'h148, a0, a1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_BOTH);
        step(1'b0, 32'h150, sp0, sp1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, M_BUB);
        step(1'b0, 32'h150, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, M_BOTH);
        step(1'b0, 32'h160, sp0, sp1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_BOTH);
`endif
        step(1'b1, 32'h168, a0, a1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_RST);
        step(1'b0, 32'h168, a0, a1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_BOTH);

        // Branch outranks execute busy.
        step(1'b0, 32'h170, a0, a1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, M_BUB);
        step(1'b0, 32'h178, a0, a1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_BOTH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
